// File: rtl/tpu_pkg.sv
// Shared types and defaults for the tpumac operand-side blocks.
package tpu_pkg;

  localparam int unsigned DEF_BITS_AB = 8;
  localparam int unsigned DEF_DIM     = 8;

  typedef logic signed [DEF_BITS_AB-1:0] elem_t;
  typedef elem_t row_t [DEF_DIM];

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/skew_buffer_pp_if.sv
// Host/array handshake bundle for skew_buffer_pp.
// `mode` exists only when SKEW_BUF_TRANSPOSE_EN is defined.
interface skew_buffer_pp_if #(
  parameter int unsigned BITS_AB = tpu_pkg::DEF_BITS_AB,
  parameter int unsigned DIM     = tpu_pkg::DEF_DIM
);
  logic                      wr_en;
  logic [$clog2(DIM)-1:0]    wr_row;
  logic signed [BITS_AB-1:0] wr_data [DIM];
  logic                      commit;
  logic                      wr_ready;
  logic                      start;
  logic                      start_ready;
  logic signed [BITS_AB-1:0] Aout [DIM];
  logic                      out_valid;
  logic                      done;
`ifdef SKEW_BUF_TRANSPOSE_EN
  logic                      mode;

  modport master (
    output wr_en, wr_row, wr_data, commit, start, mode,
    input  wr_ready, start_ready, Aout, out_valid, done
  );
  modport slave (
    input  wr_en, wr_row, wr_data, commit, start, mode,
    output wr_ready, start_ready, Aout, out_valid, done
  );
`else
  modport master (
    output wr_en, wr_row, wr_data, commit, start,
    input  wr_ready, start_ready, Aout, out_valid, done
  );
  modport slave (
    input  wr_en, wr_row, wr_data, commit, start,
    output wr_ready, start_ready, Aout, out_valid, done
  );
`endif
endinterface

// File: rtl/skew_buffer_pp_bank.sv
// One DIMxDIM operand bank: row write port, combinational diagonal read by step.
module skew_bank
  import tpu_pkg::*;
#(
  parameter int unsigned BITS_AB = DEF_BITS_AB,
  parameter int unsigned DIM     = DEF_DIM,
  parameter int unsigned CNTW    = $clog2(2*DIM)
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [$clog2(DIM)-1:0]    wrow,
  input  logic signed [BITS_AB-1:0] wdata [DIM],
  input  logic [CNTW-1:0]           step,
  input  logic                      mode,
  output logic signed [BITS_AB-1:0] rdata [DIM]
);

  logic signed [BITS_AB-1:0] mem [DIM][DIM];

  always_ff @(posedge clk) begin
    if (we) mem[wrow] <= wdata;
  end

  // Lane r picks column c where r+c == step; this avoids signed step-r arithmetic.
  always_comb begin
    for (int unsigned r = 0; r < DIM; r++) begin
      rdata[r] = '0;
      for (int unsigned c = 0; c < DIM; c++) begin
        if (step == CNTW'(r + c)) rdata[r] = mode ? mem[c][r] : mem[r][c];
      end
    end
  end

endmodule

// File: rtl/skew_buffer_pp.sv
// Ping-pong skewed A-operand buffer for the tpumac array.
// Optional transpose streaming via SKEW_BUF_TRANSPOSE_EN (adds bus.mode).
module skew_buffer_pp
  import tpu_pkg::*;
#(
  parameter int unsigned BITS_AB = DEF_BITS_AB,
  parameter int unsigned DIM     = DEF_DIM,
  parameter int unsigned CNTW    = $clog2(2*DIM)
) (
  input logic             clk,
  input logic             rst_n,
  input logic             en,
  skew_buffer_pp_if.slave bus
);

  localparam logic [CNTW-1:0] LAST = CNTW'(2*DIM - 2);

  state_t                    state, state_d;
  logic [CNTW-1:0]           step, step_d;
  logic                      wb, rb;
  logic [1:0]                full;
  logic signed [BITS_AB-1:0] aout_q [DIM];
  logic signed [BITS_AB-1:0] aout_d [DIM];
  logic signed [BITS_AB-1:0] rd0 [DIM];
  logic signed [BITS_AB-1:0] rd1 [DIM];
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;
  logic                      last;
  logic                      accept;
  logic                      wr_acc, cm_acc;
  logic                      mode_q;

  assign bus.wr_ready    = !full[wb];
  assign bus.start_ready = (state == IDLE) && full[rb];
  assign bus.Aout        = aout_q;
  assign bus.out_valid   = valid_q;
  assign bus.done        = done_q;

  assign wr_acc = bus.wr_en  && bus.wr_ready;
  assign cm_acc = bus.commit && bus.wr_ready;
  assign accept = en && (state == IDLE) && bus.start && bus.start_ready;

`ifdef SKEW_BUF_TRANSPOSE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mode_q <= 1'b0;
    else if (accept) mode_q <= bus.mode;
  end
`else
  assign mode_q = 1'b0;
`endif

  skew_bank #(.BITS_AB(BITS_AB), .DIM(DIM), .CNTW(CNTW)) u_bank0 (
    .clk   (clk),
    .we    (wr_acc && !wb),
    .wrow  (bus.wr_row),
    .wdata (bus.wr_data),
    .step  (step),
    .mode  (mode_q),
    .rdata (rd0)
  );

  skew_bank #(.BITS_AB(BITS_AB), .DIM(DIM), .CNTW(CNTW)) u_bank1 (
    .clk   (clk),
    .we    (wr_acc && wb),
    .wrow  (bus.wr_row),
    .wdata (bus.wr_data),
    .step  (step),
    .mode  (mode_q),
    .rdata (rd1)
  );

  always_comb begin
    state_d = state;
    step_d  = step;
    aout_d  = aout_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    last    = 1'b0;
    if (en) begin
      unique case (state)
        IDLE: begin
          aout_d  = '{default: '0};
          valid_d = 1'b0;
          if (accept) begin
            state_d = STREAM;
            step_d  = '0;
          end
        end
        STREAM: begin
          for (int unsigned i = 0; i < DIM; i++) aout_d[i] = rb ? rd1[i] : rd0[i];
          valid_d = 1'b1;
          if (step == LAST) begin
            done_d  = 1'b1;
            last    = 1'b1;
            state_d = IDLE;
            step_d  = '0;
          end else begin
            step_d = step + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      step    <= '0;
      aout_q  <= '{default: '0};
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      wb      <= 1'b0;
      rb      <= 1'b0;
      full    <= '0;
    end else begin
      state   <= state_d;
      step    <= step_d;
      aout_q  <= aout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (cm_acc) begin
        full[wb] <= 1'b1;
        wb       <= ~wb;
      end
      // Release after commit so the clear wins should both ever hit one bank.
      if (last) begin
        full[rb] <= 1'b0;
        rb       <= ~rb;
      end
    end
  end

endmodule

// File: tb/tb_skew_buffer_pp.sv
// Directed self-checking bench for skew_buffer_pp (DIM=8, BITS_AB=8).
module tb_skew_buffer_pp;
  import tpu_pkg::*;

  localparam int unsigned BITS_AB = 8;
  localparam int unsigned DIM     = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  int   errors = 0;
  int   checks = 0;

  skew_buffer_pp_if #(.BITS_AB(BITS_AB), .DIM(DIM)) bus ();

  skew_buffer_pp #(.BITS_AB(BITS_AB), .DIM(DIM), .CNTW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Matrix 0: 8*i+j (0..63); matrix 1: 8*i+j-64 (-64..-1).
  function automatic int mval(input int mi, input int i, input int j);
    return (mi == 0) ? (8*i + j) : (8*i + j - 64);
  endfunction

  function automatic int expv(input int mi, input int tr, input int s, input int r);
    int c;
    c = s - r;
    if (c < 0 || c >= int'(DIM)) return 0;
    return (tr != 0) ? mval(mi, c, r) : mval(mi, r, c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rows 0..6 alone, row 7 together with commit.
  task automatic load(input int mi);
    for (int i = 0; i < int'(DIM); i++) begin
      bus.wr_en  = 1'b1;
      bus.wr_row = 3'(i);
      for (int j = 0; j < int'(DIM); j++) bus.wr_data[j] = 8'(mval(mi, i, j));
      bus.commit = (i == int'(DIM) - 1);
      tick();
    end
    bus.wr_en  = 1'b0;
    bus.commit = 1'b0;
  endtask

  task automatic stream(input int mi, input int tr, input int stall_at, input string nm);
    int shown = -1;
    int span  = 0;
    int dones = 0;
    int stalls = 0;
    bit en_edge;
    bit fin = 1'b0;
    en = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({nm, "_acc_valid"}, int'(bus.out_valid), 0);
    check({nm, "_acc_sready"}, int'(bus.start_ready), 0);
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      en_edge = en;
      tick();
      if (en_edge) shown++;
      if (bus.out_valid) begin
        span++;
        for (int r = 0; r < int'(DIM); r++)
          check($sformatf("%s_s%0d_l%0d", nm, shown, r), int'(bus.Aout[r]), expv(mi, tr, shown, r));
      end
      if (bus.done) begin
        dones++;
        check({nm, "_done_step"}, shown, 14);
        fin = 1'b1;
      end
      if (stall_at >= 0 && shown == stall_at && stalls < 3) begin
        en = 1'b0;
        stalls++;
      end else begin
        en = 1'b1;
      end
    end
    en = 1'b1;
    check({nm, "_span"}, span, (stall_at >= 0) ? 18 : 15);
    check({nm, "_dones"}, dones, 1);
    tick();
    check({nm, "_post_valid"}, int'(bus.out_valid), 0);
    check({nm, "_post_done"}, int'(bus.done), 0);
  endtask

  initial begin
    bus.wr_en  = 1'b0;
    bus.wr_row = '0;
    bus.commit = 1'b0;
    bus.start  = 1'b0;
    for (int j = 0; j < int'(DIM); j++) bus.wr_data[j] = '0;
`ifdef SKEW_BUF_TRANSPOSE_EN
    bus.mode = 1'b0;
`endif

    // Reset and idle
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_wr_ready", int'(bus.wr_ready), 1);
    check("rst_start_ready", int'(bus.start_ready), 0);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_done", int'(bus.done), 0);
    for (int r = 0; r < int'(DIM); r++) check($sformatf("rst_aout%0d", r), int'(bus.Aout[r]), 0);
    rst_n = 1'b1;
    en = 1'b1;
    tick();

    // Start with empty read bank is ignored
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("empty_start_valid", int'(bus.out_valid), 0);
    check("empty_start_sready", int'(bus.start_ready), 0);

    // Single matrix, then ping-pong with M1 loaded during the stream
    load(0);
    check("m0_wr_ready", int'(bus.wr_ready), 1);
    check("m0_start_ready", int'(bus.start_ready), 1);
    fork
      stream(0, 0, -1, "m0");
      begin
        repeat (2) tick();
        load(1);
        check("pp_wr_ready_low", int'(bus.wr_ready), 0);
        check("pp_sready_busy", int'(bus.start_ready), 0);
      end
    join
    check("pp_start_ready", int'(bus.start_ready), 1);
    check("pp_wr_ready_back", int'(bus.wr_ready), 1);
    stream(1, 0, -1, "m1");
    check("pp_drained_sready", int'(bus.start_ready), 0);

    // Stall at step 4
    load(0);
    stream(0, 0, 4, "stall");

    // Both banks full, illegal write and commit ignored
    load(1);
    load(0);
    check("ovf_wr_ready", int'(bus.wr_ready), 0);
    bus.wr_en  = 1'b1;
    bus.wr_row = '0;
    for (int j = 0; j < int'(DIM); j++) bus.wr_data[j] = 8'sh7F;
    bus.commit = 1'b1;
    tick();
    bus.wr_en  = 1'b0;
    bus.commit = 1'b0;
    check("ovf_wr_ready_hold", int'(bus.wr_ready), 0);
    check("ovf_start_ready", int'(bus.start_ready), 1);
    stream(1, 0, -1, "ovf_b1");
    check("ovf_next_sready", int'(bus.start_ready), 1);
    stream(0, 0, -1, "ovf_b0");

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("empty2_valid", int'(bus.out_valid), 0);
    check("empty2_sready", int'(bus.start_ready), 0);
    check("empty2_wr_ready", int'(bus.wr_ready), 1);

`ifdef SKEW_BUF_TRANSPOSE_EN
    load(0);
    bus.mode = 1'b1;
    stream(0, 1, -1, "tr");
    bus.mode = 1'b0;
`endif

    // Reset mid-stream
    load(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    check("mid_valid_before", int'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(bus.out_valid), 0);
    check("mid_rst_wr_ready", int'(bus.wr_ready), 1);
    check("mid_rst_sready", int'(bus.start_ready), 0);
    check("mid_rst_aout3", int'(bus.Aout[3]), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_after_sready", int'(bus.start_ready), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
